mux2_rr_arbiter: RTL
====================

// Module: mux2_rr_arbiter
//
// PURPOSE
//   Two-requester round-robin arbiter that time-shares one Mux2 datapath between two
//   valid/ready streams. It generates the Mux2 select from a registered grant and
//   holds the grant for the whole of a multi-beat packet (closed by *_last).
//   The single-entry output register gives 1-cycle latency and full 1-beat/cycle throughput.
//   Sits in front of any shared single-port consumer (bus port, FIFO write side).
//
// PARAMETERS
//   WIDTH    8    payload width in bits, passed to the Mux2 instance
//   STAT_W   16   width of the beat counters (used only with MUX2_ARB_STATS_EN)
//
// PORTS
//   clk        in   1       clock; all state updates on the rising edge
//   rst        in   1       synchronous, active-high reset
//   in1_valid  in   1       requester 1 beat valid
//   in1_last   in   1       requester 1 beat is the last beat of its packet
//   in1_data   in   WIDTH   requester 1 payload
//   in1_ready  out  1       requester 1 beat accepted this cycle
//   in2_valid  in   1       requester 2 beat valid
//   in2_last   in   1       requester 2 beat is the last beat of its packet
//   in2_data   in   WIDTH   requester 2 payload
//   in2_ready  out  1       requester 2 beat accepted this cycle
//   out_valid  out  1       output beat valid (registered)
//   out_last   out  1       output beat is the last beat of its packet (registered)
//   out_src    out  1       source of the output beat: 0 = in1, 1 = in2 (registered)
//   out_data   out  WIDTH   output payload (registered; Mux2 output captured)
//   out_ready  in   1       downstream accepts the output beat
//
// BEHAVIOUR
//   - Reset: out_valid=0, out_last=0, out_src=0, out_data=0, state=IDLE, ptr=0 (in1 favoured).
//     in1_ready and in2_ready are 0 while rst=1.
//   - load = !out_valid | out_ready. No beat is accepted when load=0 (backpressure holds).
//   - Grant in IDLE:
//     - only in1_valid -> grant in1;
//     - only in2_valid -> grant in2;
//     - both valid -> grant in1 if ptr=0, else in2.
//   - Grant in LOCK1 or LOCK2: the locked source only. The other source waits even if it
//     is valid.
//   - inX_ready = load & grant==X & inX_valid. It is combinational from state, the valids
//     and out_ready.
//   - Mux2 sel = grant. The accepted beat loads out_data/out_last/out_src; out_valid<=1.
//     If load=1 and no beat is accepted, out_valid<=0.
//   - FSM IDLE/LOCK1/LOCK2. Each transition happens only on an accepted beat:
//     - beat with last=0 from X -> LOCKX;
//     - beat with last=1 -> IDLE and ptr <= ~X (the other source wins the next tie).
//     - A single-beat packet (last=1 from IDLE) stays in IDLE but still flips ptr.
//   - Starvation bound: once a packet ends, a waiting requester is served before the other
//     requester starts its next packet.
//   - Simultaneous out_ready and a new beat: the old beat leaves and the new beat loads in
//     the same cycle, with no bubble.
//   - A valid that drops while unaccepted is legal. The grant is recomputed every cycle in
//     IDLE. In LOCK the FSM waits for the locked source.
//   - Reset mid-packet: the lock is discarded, the output register is cleared and the
//     partial packet is lost.
//
// CONFIGURATION
//   MUX2_ARB_STATS_EN defined:
//     - adds output ports cnt1 and cnt2 [STAT_W-1:0], which count accepted beats per source;
//     - both counters reset to 0 and saturate at all-ones (no wrap);
//     - when a counter is saturated, its further increments are ignored.
//   MUX2_ARB_STATS_EN undefined: the ports and counters are absent and no logic is added.
//     Arbitration behaviour is identical in both configurations.
//
// TESTING
//   1. Apply rst for 2 cycles, with in1_valid=1 during reset -> in1_ready=0 and out_valid=0.
//      The first cycle after reset accepts in1 and out_src=0 follows one cycle later.
//   2. in1 and in2 both continuously valid with single-beat packets (last=1), out_ready=1
//      -> out_src alternates 0,1,0,1,... at 1 beat/cycle with no idle cycles.
//   3. in1 sends a 4-beat packet (0x11..0x14, last on 0x14) while in2 is valid throughout
//      -> out_data is 0x11,0x12,0x13,0x14 and then the in2 beat. in2_ready=0 for those
//      4 cycles.
//   4. Hold out_ready=0 for 3 cycles with out_valid=1 -> out_data is stable and both
//      ready outputs are 0. Release -> a new beat loads on the same edge the old one leaves.
//   5. Assert rst during beat 2 of a 3-beat in2 packet -> state IDLE and out_valid=0.
//      With both requesters valid next, in1 is granted (ptr=0).
//   6. With MUX2_ARB_STATS_EN and STAT_W=4, send 20 in1 beats -> cnt1 saturates at 15.
//      cnt2 stays 0.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux2_rr_arbiter (plus helper mux2)
//  Description : Two-requester round-robin arbiter that time-shares one Mux2
//                datapath between two valid/ready streams. The grant is held
//                for the whole of a multi-beat packet (closed by *_last), and
//                a single-entry output register gives 1-cycle latency at full
//                1-beat/cycle throughput.
//  Ports       : clk, rst                  - clock, synchronous active-high reset
//                in1_valid/last/data/ready - requester 1 stream
//                in2_valid/last/data/ready - requester 2 stream
//                out_valid/last/src/data   - registered output beat
//                out_ready                 - downstream accept
//                cnt1, cnt2                - saturating accepted-beat counters
//                                            (only with MUX2_ARB_STATS_EN)
//  Options     : MUX2_ARB_STATS_EN - adds STAT_W and the cnt1/cnt2 counters
//  Revision    : 1.0 - initial release
// ============================================================================

module mux2 #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? b : a;
endmodule

module mux2_rr_arbiter #(
    parameter int WIDTH = 8
`ifdef MUX2_ARB_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in1_valid,
    input  logic             in1_last,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    input  logic             in2_valid,
    input  logic             in2_last,
    input  logic [WIDTH-1:0] in2_data,
    output logic             in2_ready,
    output logic             out_valid,
    output logic             out_last,
    output logic             out_src,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef MUX2_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] cnt1,
    output logic [STAT_W-1:0] cnt2
`endif
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOCK1 = 2'd1;
    localparam logic [1:0] c_LOCK2 = 2'd2;

    logic [1:0]       r_state;
    logic             r_ptr;      // 0: in1 wins the next tie, 1: in2 wins
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_out_src;
    logic [WIDTH-1:0] r_out_data;

    logic             w_load;
    logic             w_grant;    // 0 = in1, 1 = in2
    logic             w_acc;
    logic             w_last;
    logic [WIDTH-1:0] w_mux_data;

    // The output register can take a new beat when empty or when its
    // current beat is leaving on this same edge (no bubble).
    assign w_load = !r_out_valid || out_ready;

    always_comb begin
        w_grant = r_ptr;
        case (r_state)
            c_LOCK1: w_grant = 1'b0;
            c_LOCK2: w_grant = 1'b1;
            default: begin
                if (in1_valid && (!in2_valid || !r_ptr)) begin
                    w_grant = 1'b0;
                end else if (in2_valid) begin
                    w_grant = 1'b1;
                end else begin
                    w_grant = r_ptr;
                end
            end
        endcase
    end

    assign in1_ready = !rst && w_load && !w_grant && in1_valid;
    assign in2_ready = !rst && w_load &&  w_grant && in2_valid;
    assign w_acc     = in1_ready || in2_ready;
    assign w_last    = w_grant ? in2_last : in1_last;

    mux2 #(
        .WIDTH (WIDTH)
    ) u_mux2 (
        .sel (w_grant),
        .a   (in1_data),
        .b   (in2_data),
        .y   (w_mux_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_ptr       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_src   <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= w_acc;
            end
            if (w_acc) begin
                r_out_data <= w_mux_data;
                r_out_last <= w_last;
                r_out_src  <= w_grant;
                if (w_last) begin
                    // Packet closed: hand the next tie to the other source.
                    r_state <= c_IDLE;
                    r_ptr   <= ~w_grant;
                end else begin
                    r_state <= w_grant ? c_LOCK2 : c_LOCK1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;
    assign out_data  = r_out_data;

`ifdef MUX2_ARB_STATS_EN
    logic [STAT_W-1:0] r_cnt1;
    logic [STAT_W-1:0] r_cnt2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else begin
            if (in1_ready && (r_cnt1 != {STAT_W{1'b1}})) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
            if (in2_ready && (r_cnt2 != {STAT_W{1'b1}})) begin
                r_cnt2 <= r_cnt2 + 1'b1;
            end
        end
    end

    assign cnt1 = r_cnt1;
    assign cnt2 = r_cnt2;
`endif

endmodule
`default_nettype wire
